// File: rtl/sctag_rddata_eccchk_if.sv
// Read-data bus between scdata return and sctag fill logic: C5 input side,
// corrected C7 output side, and the error-log / CE-counter readout.
interface sctag_rddata_eccchk_if #(
  parameter int CNT_W = 8
);
  logic             scdata_rd_vld_c5;
  logic [77:0]      scdata_rd_data_c5;
  logic             err_log_clr;
  logic             rd_vld_c7;
  logic [63:0]      rd_data_c7;
  logic [1:0]       rd_ce_c7;
  logic [1:0]       rd_ue_c7;
  logic             err_log_vld;
  logic             err_log_ue;
  logic             err_log_word;
  logic [6:0]       err_log_syn;
  logic [CNT_W-1:0] ce_cnt;

  modport master (
    output scdata_rd_vld_c5, scdata_rd_data_c5, err_log_clr,
    input  rd_vld_c7, rd_data_c7, rd_ce_c7, rd_ue_c7,
    input  err_log_vld, err_log_ue, err_log_word, err_log_syn, ce_cnt
  );

  modport slave (
    input  scdata_rd_vld_c5, scdata_rd_data_c5, err_log_clr,
    output rd_vld_c7, rd_data_c7, rd_ce_c7, rd_ue_c7,
    output err_log_vld, err_log_ue, err_log_word, err_log_syn, ce_cnt
  );
endinterface

// File: rtl/sctag_rddata_eccchk.sv
// Two-word SECDED check/correct of scdata read data (C5 -> C7), sticky error log
// and saturating CE counter. Define SCTAG_RDDATA_ERRINJ_EN to add the err_inj port.
module sctag_rddata_eccchk #(
  parameter int CNT_W = 8
) (
  input  logic rclk,
  input  logic arst_l,
`ifdef SCTAG_RDDATA_ERRINJ_EN
  input  logic err_inj,
`endif
  sctag_rddata_eccchk_if.slave bus
);

  typedef struct packed {
    logic [31:0] data;
    logic        ce;
    logic        ue;
    logic [6:0]  syn;
  } dec_t;

  // cw[0] holds the overall parity bit, cw[n] holds Hamming position n.
  function automatic dec_t ecc_decode(input logic [38:0] w);
    logic [38:0] cw;
    logic [5:0]  s;
    logic        p;
    int          di;
    dec_t        r;
    cw    = '0;
    cw[0] = w[6];
    for (int k = 0; k < 6; k++) cw[1 << k] = w[k];
    di = 0;
    for (int n = 3; n <= 38; n++) begin
      if ((n & (n - 1)) != 0) begin
        cw[n] = w[7 + di];
        di    = di + 1;
      end
    end
    s = '0;
    for (int n = 1; n <= 38; n++) if (cw[n]) s = s ^ n[5:0];
    p      = ^cw;
    r.syn  = {p, s};
    r.ce   = p && (s <= 6'd38);
    r.ue   = (!p && (s != 6'd0)) || (p && (s > 6'd38));
    if (r.ce) cw[s] = ~cw[s];
    r.data = '0;
    di     = 0;
    for (int n = 3; n <= 38; n++) begin
      if ((n & (n - 1)) != 0) begin
        r.data[di] = cw[n];
        di         = di + 1;
      end
    end
    return r;
  endfunction

  logic              vld_c6_q, vld_c6_d;
  logic [77:0]       data_c6_q, data_c6_d;
  logic              rd_vld_c7_q, rd_vld_c7_d;
  logic [63:0]       rd_data_c7_q, rd_data_c7_d;
  logic [1:0]        rd_ce_c7_q, rd_ce_c7_d;
  logic [1:0]        rd_ue_c7_q, rd_ue_c7_d;
  logic [6:0]        syn0_c7_q, syn0_c7_d, syn1_c7_q, syn1_c7_d;
  logic              log_vld_q, log_vld_d, log_ue_q, log_ue_d, log_word_q, log_word_d;
  logic [6:0]        log_syn_q, log_syn_d;
  logic [CNT_W-1:0]  ce_cnt_q, ce_cnt_d;
  logic [CNT_W:0]    cnt_sum;
  dec_t              dec0, dec1;
  logic              new_err, new_ue, new_word;
  logic [6:0]        new_syn;

  // C5 -> C6: capture, with optional forced flip of word0 d[0]
  always_comb begin
    vld_c6_d  = bus.scdata_rd_vld_c5;
    data_c6_d = bus.scdata_rd_data_c5;
`ifdef SCTAG_RDDATA_ERRINJ_EN
    if (err_inj && bus.scdata_rd_vld_c5) data_c6_d[7] = ~data_c6_d[7];
`endif
  end

  // C6 -> C7: decode/correct; data and syndromes hold while invalid
  always_comb begin
    dec0         = ecc_decode(data_c6_q[38:0]);
    dec1         = ecc_decode(data_c6_q[77:39]);
    rd_vld_c7_d  = vld_c6_q;
    rd_data_c7_d = rd_data_c7_q;
    rd_ce_c7_d   = 2'b00;
    rd_ue_c7_d   = 2'b00;
    syn0_c7_d    = syn0_c7_q;
    syn1_c7_d    = syn1_c7_q;
    if (vld_c6_q) begin
      rd_data_c7_d = {dec1.data, dec0.data};
      rd_ce_c7_d   = {dec1.ce, dec0.ce};
      rd_ue_c7_d   = {dec1.ue, dec0.ue};
      syn0_c7_d    = dec0.syn;
      syn1_c7_d    = dec1.syn;
    end
  end

  // C7 consumers: sticky log (UE outranks CE, word0 breaks ties, set beats clear)
  always_comb begin
    new_err    = rd_vld_c7_q && ((|rd_ue_c7_q) || (|rd_ce_c7_q));
    new_ue     = |rd_ue_c7_q;
    new_word   = new_ue ? ~rd_ue_c7_q[0] : ~rd_ce_c7_q[0];
    new_syn    = new_word ? syn1_c7_q : syn0_c7_q;
    log_vld_d  = log_vld_q;
    log_ue_d   = log_ue_q;
    log_word_d = log_word_q;
    log_syn_d  = log_syn_q;
    if (bus.err_log_clr) begin
      log_vld_d  = 1'b0;
      log_ue_d   = 1'b0;
      log_word_d = 1'b0;
      log_syn_d  = '0;
    end
    if (new_err && (bus.err_log_clr || !log_vld_q || (!log_ue_q && new_ue))) begin
      log_vld_d  = 1'b1;
      log_ue_d   = new_ue;
      log_word_d = new_word;
      log_syn_d  = new_syn;
    end
    cnt_sum  = {1'b0, ce_cnt_q}
             + (CNT_W+1)'({1'b0, rd_ce_c7_q[1]} + {1'b0, rd_ce_c7_q[0]});
    ce_cnt_d = ce_cnt_q;
    if (rd_vld_c7_q) ce_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      vld_c6_q     <= 1'b0;
      data_c6_q    <= '0;
      rd_vld_c7_q  <= 1'b0;
      rd_data_c7_q <= '0;
      rd_ce_c7_q   <= '0;
      rd_ue_c7_q   <= '0;
      syn0_c7_q    <= '0;
      syn1_c7_q    <= '0;
      log_vld_q    <= 1'b0;
      log_ue_q     <= 1'b0;
      log_word_q   <= 1'b0;
      log_syn_q    <= '0;
      ce_cnt_q     <= '0;
    end else begin
      vld_c6_q     <= vld_c6_d;
      data_c6_q    <= data_c6_d;
      rd_vld_c7_q  <= rd_vld_c7_d;
      rd_data_c7_q <= rd_data_c7_d;
      rd_ce_c7_q   <= rd_ce_c7_d;
      rd_ue_c7_q   <= rd_ue_c7_d;
      syn0_c7_q    <= syn0_c7_d;
      syn1_c7_q    <= syn1_c7_d;
      log_vld_q    <= log_vld_d;
      log_ue_q     <= log_ue_d;
      log_word_q   <= log_word_d;
      log_syn_q    <= log_syn_d;
      ce_cnt_q     <= ce_cnt_d;
    end
  end

  assign bus.rd_vld_c7    = rd_vld_c7_q;
  assign bus.rd_data_c7   = rd_data_c7_q;
  assign bus.rd_ce_c7     = rd_ce_c7_q;
  assign bus.rd_ue_c7     = rd_ue_c7_q;
  assign bus.err_log_vld  = log_vld_q;
  assign bus.err_log_ue   = log_ue_q;
  assign bus.err_log_word = log_word_q;
  assign bus.err_log_syn  = log_syn_q;
  assign bus.ce_cnt       = ce_cnt_q;

endmodule

// File: tb/tb_sctag_rddata_eccchk.sv
// Bench for sctag_rddata_eccchk: directed scenarios plus random traffic against
// a nearest-codeword reference model. Honours SCTAG_RDDATA_ERRINJ_EN.
module tb_sctag_rddata_eccchk;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;
  typedef logic [86:0] ovec_t;

  logic rclk = 1'b0;
  logic arst_l = 1'b0;
  logic inj_s = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  sctag_rddata_eccchk_if #(.CNT_W(CNT_W)) bus ();

  sctag_rddata_eccchk #(.CNT_W(CNT_W)) dut (
    .rclk   (rclk),
    .arst_l (arst_l),
`ifdef SCTAG_RDDATA_ERRINJ_EN
    .err_inj(inj_s),
`endif
    .bus    (bus)
  );

  always #5 rclk = ~rclk;

  // reference model state: pending C6 input, visible C7 outputs, log, counter
  logic        p_vld;
  logic [77:0] p_data;
  logic        m_vld;
  logic [63:0] m_data;
  logic [1:0]  m_ce, m_ue;
  logic [6:0]  m_syn0, m_syn1;
  logic        m_log_vld, m_log_ue, m_log_word;
  logic [6:0]  m_log_syn;
  int          m_cnt;

  // Hamming position -> bit index inside {data[31:0], ecc[6:0]}
  function automatic int pos2bit(input int pos);
    int di = 0;
    if (pos == 0) return 6;
    for (int k = 0; k < 6; k++) if (pos == (1 << k)) return k;
    for (int n = 3; n < pos; n++) if ((n & (n - 1)) != 0) di++;
    return 7 + di;
  endfunction

  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [38:0] w;
    w = '0;
    w[38:7] = d;
    for (int k = 0; k < 6; k++)
      for (int n = 3; n <= 38; n++)
        if (((n & (n - 1)) != 0) && (((n >> k) & 1) == 1)) w[k] = w[k] ^ w[pos2bit(n)];
    w[6] = ^{w[38:7], w[5:0]};
    return w;
  endfunction

  function automatic logic [38:0] flip(input logic [38:0] w, input int pos);
    logic [38:0] r;
    r = w;
    r[pos2bit(pos)] = ~r[pos2bit(pos)];
    return r;
  endfunction

  // classify by searching for a codeword within distance 1
  function automatic void mdec(input logic [38:0] w, output logic [31:0] d,
                               output logic ce, output logic ue, output logic [6:0] syn);
    logic [38:0] t;
    logic [38:0] re;
    re  = enc(w[38:7]);
    syn = {^w, re[5:0] ^ w[5:0]};
    d   = w[38:7];
    ce  = 1'b0;
    ue  = 1'b0;
    if (re != w) begin
      ue = 1'b1;
      for (int b = 0; b < 39; b++) begin
        t = w ^ (39'(1) << b);
        if (enc(t[38:7]) == t) begin
          ce = 1'b1;
          ue = 1'b0;
          d  = t[38:7];
        end
      end
    end
  endfunction

  function automatic void model_clear();
    p_vld = 0; p_data = '0; m_vld = 0; m_data = '0; m_ce = '0; m_ue = '0;
    m_syn0 = '0; m_syn1 = '0; m_log_vld = 0; m_log_ue = 0; m_log_word = 0;
    m_log_syn = '0; m_cnt = 0;
  endfunction

  function automatic void model_edge(input logic vld, input logic [77:0] d,
                                     input logic clr, input logic inj);
    logic err, nu, nw;
    logic [31:0] d0, d1;
    logic c0, c1, u0, u1;
    logic [6:0] s0, s1;
    err = m_vld && ((m_ue != 0) || (m_ce != 0));
    nu  = (m_ue != 0);
    nw  = nu ? !m_ue[0] : !m_ce[0];
    if (clr) begin
      m_log_vld = 0; m_log_ue = 0; m_log_word = 0; m_log_syn = '0;
    end
    if (err && (clr || !m_log_vld || (!m_log_ue && nu))) begin
      m_log_vld = 1; m_log_ue = nu; m_log_word = nw; m_log_syn = nw ? m_syn1 : m_syn0;
    end
    if (m_vld) m_cnt = (m_cnt + int'(m_ce[0]) + int'(m_ce[1]) > CMAX) ? CMAX
                                                                     : m_cnt + int'(m_ce[0]) + int'(m_ce[1]);
    m_vld = p_vld;
    m_ce  = '0;
    m_ue  = '0;
    if (p_vld) begin
      mdec(p_data[38:0], d0, c0, u0, s0);
      mdec(p_data[77:39], d1, c1, u1, s1);
      m_data = {d1, d0}; m_ce = {c1, c0}; m_ue = {u1, u0}; m_syn0 = s0; m_syn1 = s1;
    end
    p_vld  = vld;
    p_data = d;
    if (inj && vld) p_data[7] = ~p_data[7];
  endfunction

  function automatic ovec_t got_vec();
    return {bus.rd_vld_c7, bus.rd_data_c7, bus.rd_ce_c7, bus.rd_ue_c7, bus.err_log_vld,
            bus.err_log_ue, bus.err_log_word, bus.err_log_syn, bus.ce_cnt};
  endfunction

  function automatic ovec_t exp_vec();
    return {m_vld, m_data, m_ce, m_ue, m_log_vld, m_log_ue, m_log_word, m_log_syn,
            CNT_W'(m_cnt)};
  endfunction

  task automatic cyc(input logic vld, input logic [77:0] d, input logic clr, input logic inj);
    bus.scdata_rd_vld_c5  = vld;
    bus.scdata_rd_data_c5 = d;
    bus.err_log_clr       = clr;
    inj_s                 = inj;
    @(posedge rclk);
    #1;
    model_edge(vld, d, clr, inj);
  endtask

  task automatic do_reset();
    bus.scdata_rd_vld_c5 = 0; bus.scdata_rd_data_c5 = '0; bus.err_log_clr = 0; inj_s = 0;
    arst_l = 0;
    model_clear();
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    arst_l = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (got_vec() !== ovec_t'(0)) $display("FAIL reset_state got=%h exp=0", got_vec());
    else n_pass++;
  endtask

  task automatic test_clean();
    logic [38:0] e;
    e = enc(32'hDEADBEEF);
    cyc(1, {e, e}, 0, 0);
    n_checks++;
    if (bus.rd_vld_c7 !== 1'b0) $display("FAIL clean_latency1 got=%b exp=0", bus.rd_vld_c7);
    else n_pass++;
    cyc(0, '0, 0, 0);
    n_checks++;
    if ({bus.rd_vld_c7, bus.rd_data_c7, bus.rd_ce_c7, bus.rd_ue_c7, bus.ce_cnt} !==
        {1'b1, 64'hDEADBEEF_DEADBEEF, 4'b0000, 8'd0})
      $display("FAIL clean_out got=%b_%h_%b_%b_%0d", bus.rd_vld_c7, bus.rd_data_c7,
               bus.rd_ce_c7, bus.rd_ue_c7, bus.ce_cnt);
    else n_pass++;
    n_checks++;
    if (got_vec() !== exp_vec()) $display("FAIL clean_model got=%h exp=%h", got_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_single_flip();
    cyc(1, {flip(enc(32'h0), 3), enc(32'h0)}, 0, 0);
    cyc(0, '0, 0, 0);
    n_checks++;
    if ({bus.rd_data_c7[63:32], bus.rd_ce_c7, bus.rd_ue_c7} !== {32'h0, 2'b10, 2'b00})
      $display("FAIL single_ce got=%h ce=%b ue=%b exp=0 ce=10 ue=00", bus.rd_data_c7[63:32],
               bus.rd_ce_c7, bus.rd_ue_c7);
    else n_pass++;
    cyc(0, '0, 0, 0);
    n_checks++;
    if ({bus.err_log_vld, bus.err_log_ue, bus.err_log_word, bus.err_log_syn, bus.ce_cnt} !==
        {3'b101, 7'b1000011, 8'd1})
      $display("FAIL single_log got=%b%b%b syn=%b cnt=%0d exp=101 syn=1000011 cnt=1",
               bus.err_log_vld, bus.err_log_ue, bus.err_log_word, bus.err_log_syn, bus.ce_cnt);
    else n_pass++;
  endtask

  task automatic test_double();
    cyc(1, {enc(32'h0), flip(flip(enc(32'h0), 3), 5)}, 0, 0);
    cyc(0, '0, 0, 0);
    n_checks++;
    if ({bus.rd_data_c7[31:0], bus.rd_ce_c7, bus.rd_ue_c7} !== {32'h3, 2'b00, 2'b01})
      $display("FAIL double_ue got=%h ce=%b ue=%b exp=3 ce=00 ue=01", bus.rd_data_c7[31:0],
               bus.rd_ce_c7, bus.rd_ue_c7);
    else n_pass++;
    cyc(0, '0, 0, 0);
    n_checks++;
    if ({bus.err_log_vld, bus.err_log_ue, bus.err_log_word, bus.err_log_syn} !== {3'b110, 7'b0000110})
      $display("FAIL double_log got=%b%b%b syn=%b exp=110 syn=0000110", bus.err_log_vld,
               bus.err_log_ue, bus.err_log_word, bus.err_log_syn);
    else n_pass++;
    cyc(1, {enc(32'h0), flip(enc(32'h0), 3)}, 0, 0);
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 0);
    n_checks++;
    if ({bus.err_log_vld, bus.err_log_ue, bus.err_log_word, bus.err_log_syn, bus.ce_cnt} !==
        {3'b110, 7'b0000110, 8'd2})
      $display("FAIL ue_log_sticky got=%b%b%b syn=%b cnt=%0d exp=110 syn=0000110 cnt=2",
               bus.err_log_vld, bus.err_log_ue, bus.err_log_word, bus.err_log_syn, bus.ce_cnt);
    else n_pass++;
  endtask

  task automatic test_clr_same_cycle();
    cyc(1, {enc(32'h5), flip(enc(32'h5), 6)}, 0, 0);
    cyc(0, '0, 0, 0);
    cyc(0, '0, 1, 0);
    n_checks++;
    if ({bus.err_log_vld, bus.err_log_ue, bus.err_log_word, bus.err_log_syn} !== {3'b100, 7'b1000110})
      $display("FAIL clr_set_wins got=%b%b%b syn=%b exp=100 syn=1000110", bus.err_log_vld,
               bus.err_log_ue, bus.err_log_word, bus.err_log_syn);
    else n_pass++;
    cyc(0, '0, 1, 0);
    n_checks++;
    if ({bus.err_log_vld, bus.ce_cnt} !== {1'b0, 8'd3})
      $display("FAIL clr_only got=vld%b cnt%0d exp=vld0 cnt3", bus.err_log_vld, bus.ce_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [38:0] w [2];
    logic vld, clr;
    int errs = 0;
    for (int i = 0; i < 300; i++) begin
      vld = ($urandom_range(3) != 0);
      clr = ($urandom_range(15) == 0);
      for (int k = 0; k < 2; k++) begin
        w[k] = enc($urandom);
        case ($urandom_range(7))
          0, 1, 2: ;
          3, 4:    w[k] = w[k] ^ (39'(1) << $urandom_range(38));
          5, 6:    w[k] = w[k] ^ (39'(1) << $urandom_range(38)) ^ (39'(1) << $urandom_range(38));
          default: w[k] = {$urandom, 7'($urandom)};
        endcase
      end
      cyc(vld, {w[1], w[0]}, clr, 0);
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        if (errs < 10) $display("FAIL random_cycle%0d got=%h exp=%h", i, got_vec(), exp_vec());
        errs++;
      end else n_pass++;
    end
  endtask

  task automatic test_saturation();
    int vld_seen = 0;
    do_reset();
    for (int i = 0; i < 132; i++) begin
      if (i < 130)
        cyc(1, {enc($urandom) ^ (39'(1) << $urandom_range(38)),
                enc($urandom) ^ (39'(1) << $urandom_range(38))}, 0, 0);
      else cyc(0, '0, 0, 0);
      if (bus.rd_vld_c7 === 1'b1) vld_seen++;
    end
    n_checks++;
    if (vld_seen != 130) $display("FAIL sat_no_gaps got=%0d exp=130", vld_seen);
    else n_pass++;
    n_checks++;
    if (bus.ce_cnt !== 8'hFF) $display("FAIL sat_count got=%0d exp=255", bus.ce_cnt);
    else n_pass++;
    n_checks++;
    if (got_vec() !== exp_vec()) $display("FAIL sat_model got=%h exp=%h", got_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    logic [38:0] e;
    int bad = 0;
    e = enc(32'hCAFEF00D);
    cyc(1, {e, e}, 0, 0);
    cyc(1, {flip(e, 7), e}, 0, 0);
    bus.scdata_rd_vld_c5 = 0;
    #2;
    arst_l = 0;
    model_clear();
    #1;
    n_checks++;
    if (got_vec() !== ovec_t'(0)) $display("FAIL midreset_state got=%h exp=0", got_vec());
    else n_pass++;
    @(posedge rclk);
    @(negedge rclk);
    arst_l = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, 0, 0);
      if (bus.rd_vld_c7 !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL midreset_no_vld got=%0d pulses exp=0", bad);
    else n_pass++;
    cyc(1, {e, flip(e, 0)}, 0, 0);
    cyc(0, '0, 0, 0);
    n_checks++;
    if ({bus.rd_vld_c7, bus.rd_data_c7, bus.rd_ce_c7} !== {1'b1, 64'hCAFEF00D_CAFEF00D, 2'b01})
      $display("FAIL midreset_resume got=%b_%h_%b exp=1_cafef00dcafef00d_01", bus.rd_vld_c7,
               bus.rd_data_c7, bus.rd_ce_c7);
    else n_pass++;
  endtask

`ifdef SCTAG_RDDATA_ERRINJ_EN
  task automatic test_err_inj();
    logic [38:0] e;
    e = enc(32'h12345678);
    do_reset();
    cyc(1, {e, e}, 0, 1);
    cyc(0, '0, 0, 0);
    n_checks++;
    if ({bus.rd_ce_c7, bus.rd_ue_c7, bus.rd_data_c7} !== {2'b01, 2'b00, 64'h12345678_12345678})
      $display("FAIL err_inj got=ce%b ue%b %h exp=ce01 ue00 1234567812345678", bus.rd_ce_c7,
               bus.rd_ue_c7, bus.rd_data_c7);
    else n_pass++;
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_clean();
    test_single_flip();
    test_double();
    test_clr_same_cycle();
    test_random();
    test_saturation();
    test_reset_midstream();
`ifdef SCTAG_RDDATA_ERRINJ_EN
    test_err_inj();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
